// File: rtl/serial_magnitude_compare_if.sv
// Operand/result handshake bundle for serial_magnitude_compare.
// master = producer/consumer side, slave = comparator side.
interface serial_magnitude_compare_if #(
    parameter int WIDTH = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic             lt;
    logic             eq;
    logic             gt;
    logic             busy;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, lt, eq, gt, busy
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, lt, eq, gt, busy
    );
endinterface

// File: rtl/serial_magnitude_compare.sv
// Wide magnitude comparator stepping one 3-bit slice per clock, MSB chunk first.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish as soon as the first differing chunk is seen.
module serial_magnitude_compare #(
    parameter int WIDTH  = 12,
    parameter int SIGNED = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    serial_magnitude_compare_if.slave   bus
);
    localparam int CHUNKS = (WIDTH + 2) / 3;
    localparam int EXT    = 3 * CHUNKS;
    localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(CHUNKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [1:0] {R_EQ, R_LT, R_GT} res_t;

    state_t           state_q, state_d;
    res_t             res_q, res_d, chunk_res, res_step;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [EXT-1:0]   a_q, a_d, b_q, b_d, a_lat, b_lat;
    logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
    logic [2:0]       a_chunk [CHUNKS];
    logic [2:0]       b_chunk [CHUNKS];
    logic [2:0]       a_cur, b_cur;
    logic             finish;

    genvar gi;
    generate
        for (gi = 0; gi < CHUNKS; gi++) begin : g_chunk
            assign a_chunk[gi] = a_q[3*gi +: 3];
            assign b_chunk[gi] = b_q[3*gi +: 3];
        end
    endgenerate

    // Sign bias maps two's-complement order onto unsigned order; extension follows it.
    always_comb begin
        a_lat = '0;
        b_lat = '0;
        a_lat[WIDTH-1:0] = bus.a_in;
        b_lat[WIDTH-1:0] = bus.b_in;
        if (SIGNED != 0) begin
            a_lat[WIDTH-1] = ~bus.a_in[WIDTH-1];
            b_lat[WIDTH-1] = ~bus.b_in[WIDTH-1];
        end
    end

    always_comb begin
        a_cur     = a_chunk[idx_q];
        b_cur     = b_chunk[idx_q];
        chunk_res = R_EQ;
        if (a_cur < b_cur) begin
            chunk_res = R_LT;
        end else if (a_cur > b_cur) begin
            chunk_res = R_GT;
        end
        // The first differing chunk (from the top) decides; later chunks cannot override it.
        res_step = (res_q == R_EQ) ? chunk_res : res_q;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        finish = (idx_q == '0) || (res_step != R_EQ);
`else
        finish = (idx_q == '0);
`endif
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        res_d   = res_q;
        a_d     = a_q;
        b_d     = b_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = a_lat;
                    b_d     = b_lat;
                    idx_d   = IDX_TOP;
                    res_d   = R_EQ;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_d = res_step;
                if (finish) begin
                    lt_d    = (res_step == R_LT);
                    eq_d    = (res_step == R_EQ);
                    gt_d    = (res_step == R_GT);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            res_q   <= R_EQ;
            a_q     <= '0;
            b_q     <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            a_q     <= a_d;
            b_q     <= b_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
        end
    end

    // Handshake outputs decode only the state register, so reset clears them at once.
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.lt        = lt_q;
    assign bus.eq        = eq_q;
    assign bus.gt        = gt_q;
endmodule

// File: tb/tb_serial_magnitude_compare.sv
// Directed bench: unit 0 = WIDTH 12 unsigned, unit 1 = WIDTH 12 signed, unit 2 = WIDTH 10 unsigned.
// Expected latencies follow SERIAL_CMP_EARLY_EXIT_EN when the bench is built with it.
module tb_serial_magnitude_compare;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        iv_t [3];
    logic        or_t [3];
    logic [11:0] a_t  [3];
    logic [11:0] b_t  [3];
    logic        ir_t [3];
    logic        ov_t [3];
    logic        lt_t [3];
    logic        eq_t [3];
    logic        gt_t [3];
    logic        bz_t [3];

    serial_magnitude_compare_if #(.WIDTH(12)) if0 ();
    serial_magnitude_compare_if #(.WIDTH(12)) if1 ();
    serial_magnitude_compare_if #(.WIDTH(10)) if2 ();

    serial_magnitude_compare #(.WIDTH(12), .SIGNED(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    serial_magnitude_compare #(.WIDTH(12), .SIGNED(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    serial_magnitude_compare #(.WIDTH(10), .SIGNED(0)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    assign if0.in_valid = iv_t[0];  assign if0.out_ready = or_t[0];
    assign if0.a_in = a_t[0];       assign if0.b_in = b_t[0];
    assign if1.in_valid = iv_t[1];  assign if1.out_ready = or_t[1];
    assign if1.a_in = a_t[1];       assign if1.b_in = b_t[1];
    assign if2.in_valid = iv_t[2];  assign if2.out_ready = or_t[2];
    assign if2.a_in = a_t[2][9:0];  assign if2.b_in = b_t[2][9:0];

    assign ir_t[0] = if0.in_ready;  assign ov_t[0] = if0.out_valid;
    assign lt_t[0] = if0.lt;        assign eq_t[0] = if0.eq;
    assign gt_t[0] = if0.gt;        assign bz_t[0] = if0.busy;
    assign ir_t[1] = if1.in_ready;  assign ov_t[1] = if1.out_valid;
    assign lt_t[1] = if1.lt;        assign eq_t[1] = if1.eq;
    assign gt_t[1] = if1.gt;        assign bz_t[1] = if1.busy;
    assign ir_t[2] = if2.in_ready;  assign ov_t[2] = if2.out_valid;
    assign lt_t[2] = if2.lt;        assign eq_t[2] = if2.eq;
    assign gt_t[2] = if2.gt;        assign bz_t[2] = if2.busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Cycles from accept to first out_valid when chunk k (1 = MSB chunk) decides; all units have 4 chunks.
    function automatic int lat_of(input int k);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        return k + 1;
`else
        return 5;
`endif
    endfunction

    function automatic logic [2:0] res3(input int u);
        return {lt_t[u], eq_t[u], gt_t[u]};
    endfunction

    // exp = {lt,eq,gt}; hold = DONE cycles with out_ready low while a foreign pair is offered.
    task automatic run_pair(input int u, input logic [11:0] av, input logic [11:0] bv,
                            input logic [2:0] exp, input int k, input int hold, input string tag);
        int n;
        check({tag, ".in_ready"}, 32'(ir_t[u]), 32'd1);
        a_t[u] = av;
        b_t[u] = bv;
        iv_t[u] = 1'b1;
        @(posedge clk); #1;
        iv_t[u] = 1'b0;
        a_t[u] = 12'h000;
        b_t[u] = 12'h000;
        n = 1;
        while (!ov_t[u] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'(lat_of(k)));
        check({tag, ".result"}, 32'(res3(u)), 32'(exp));
        check({tag, ".busy"}, 32'(bz_t[u]), 32'd1);
        for (int h = 0; h < hold; h++) begin
            a_t[u] = 12'hFFF;
            b_t[u] = 12'h000;
            iv_t[u] = 1'b1;
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, 32'(ov_t[u]), 32'd1);
            check({tag, ".hold_result"}, 32'(res3(u)), 32'(exp));
            check({tag, ".hold_in_ready"}, 32'(ir_t[u]), 32'd0);
        end
        iv_t[u] = 1'b0;
        or_t[u] = 1'b1;
        @(posedge clk); #1;
        or_t[u] = 1'b0;
        check({tag, ".out_valid_drop"}, 32'(ov_t[u]), 32'd0);
        check({tag, ".in_ready_back"}, 32'(ir_t[u]), 32'd1);
        check({tag, ".result_held"}, 32'(res3(u)), 32'(exp));
        $display("txn %s unit=%0d a=%03h b=%03h ltegt=%03b latency=%0d", tag, u, av, bv, res3(u), n);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            iv_t[i] = 1'b0;
            or_t[i] = 1'b0;
            a_t[i] = 12'h000;
            b_t[i] = 12'h000;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset.in_ready", 32'(ir_t[i]), 32'd1);
            check("reset.out_valid", 32'(ov_t[i]), 32'd0);
            check("reset.result", 32'(res3(i)), 32'd0);
            check("reset.busy", 32'(bz_t[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_pair(0, 12'hABC, 12'hABC, 3'b010, 4, 0, "u12_eq");
        run_pair(0, 12'h800, 12'h7FF, 3'b001, 1, 0, "u12_msb_gt");
        run_pair(0, 12'h123, 12'h124, 3'b100, 4, 0, "u12_lsb_lt");
        run_pair(0, 12'h000, 12'hFFF, 3'b100, 1, 0, "u12_min_max");
        run_pair(1, 12'h800, 12'h001, 3'b100, 1, 0, "s12_neg_lt");
        run_pair(1, 12'hFFF, 12'hFFE, 3'b001, 4, 0, "s12_m1_gt_m2");
        run_pair(1, 12'h7FF, 12'h800, 3'b001, 1, 0, "s12_max_gt_min");
        run_pair(1, 12'h555, 12'h555, 3'b010, 4, 0, "s12_eq");
        run_pair(2, 12'h3FF, 12'h3FE, 3'b001, 4, 0, "u10_lsb_gt");
        run_pair(2, 12'h200, 12'h100, 3'b001, 1, 0, "u10_top_gt");
        run_pair(2, 12'h155, 12'h155, 3'b010, 4, 0, "u10_eq");

        // Backpressure, then the next pair goes in the cycle after release.
        run_pair(0, 12'h010, 12'h020, 3'b100, 3, 3, "u12_backpressure");
        run_pair(0, 12'h000, 12'h001, 3'b100, 4, 0, "u12_after_bp");

        // Abort mid-RUN with an asynchronous reset pulse away from the clock edge.
        a_t[0] = 12'hFFF;
        b_t[0] = 12'h000;
        iv_t[0] = 1'b1;
        @(posedge clk); #1;
        iv_t[0] = 1'b0;
        @(posedge clk); #1;
        check("abort.busy_before", 32'(bz_t[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort.out_valid", 32'(ov_t[0]), 32'd0);
        check("abort.busy", 32'(bz_t[0]), 32'd0);
        check("abort.in_ready", 32'(ir_t[0]), 32'd1);
        check("abort.result", 32'(res3(0)), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("abort.no_result", 32'(ov_t[0]), 32'd0);
        end
        $display("txn abort unit=0 a=fff b=000 discarded");
        run_pair(0, 12'h001, 12'h002, 3'b100, 4, 0, "u12_after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
